// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the chunked sequential adder/subtractor.
package addsub_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefChunk = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/chunk_addsub.sv
// CHUNK-bit add/subtract slice: y/co = a + (b ^ {sel}) + ci; cmsb is the carry into the top bit.
module chunk_addsub #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sel,
  input  logic             ci,
  output logic [CHUNK-1:0] y,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   sum;

  // Slice sum; carry into the top bit recovered from the top sum bit and its operands.
  always_comb begin
    bx   = b ^ {CHUNK{sel}};
    sum  = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, ci};
    y    = sum[CHUNK-1:0];
    co   = sum[CHUNK];
    cmsb = sum[CHUNK-1] ^ a[CHUNK-1] ^ bx[CHUNK-1];
  end

endmodule

// File: rtl/seq_addsub.sv
// Sequential adder/subtractor: processes CHUNK bits per clock over WIDTH/CHUNK RUN cycles,
// with a valid/ready handshake on both operand and result sides.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ov,
  output logic             z
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned CNTW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNTW-1:0] LastCnt = CNTW'(NCH - 1);

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              sel_q, sel_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              co_q, co_d;
  logic              ov_q, ov_d;
  logic              z_q, z_d;

  logic [CHUNK-1:0]  a_chunk, b_chunk, ch_y;
  logic              ch_co, ch_cmsb;
  logic [WIDTH-1:0]  y_next;

  // Select the operand slice addressed by the chunk counter.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (cnt_q == CNTW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_addsub #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .sel  (sel_q),
    .ci   (carry_q),
    .y    (ch_y),
    .co   (ch_co),
    .cmsb (ch_cmsb)
  );

  // Result with the current chunk written into its slice.
  always_comb begin
    y_next = y_q;
    for (int k = 0; k < int'(NCH); k++) begin
      if (cnt_q == CNTW'(k)) begin
        y_next[k*CHUNK +: CHUNK] = ch_y;
      end
    end
  end

  // Next-state: accept in IDLE, one chunk per RUN cycle, hold result in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    y_d     = y_q;
    co_d    = co_q;
    ov_d    = ov_q;
    z_d     = z_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sel_d   = sel;
          carry_d = ci;
          cnt_d   = '0;
          y_d     = '0;
          co_d    = 1'b0;
          ov_d    = 1'b0;
          z_d     = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        y_d     = y_next;
        carry_d = ch_co;
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          co_d    = ch_co;
          ov_d    = ch_cmsb ^ ch_co;
          z_d     = (y_next == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = y_q;
  assign co        = co_q;
  assign ov        = ov_q;
  assign z         = z_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub at WIDTH=16, CHUNK=4.
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sel;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        co;
  logic        ov;
  logic        z;

  int n_cmp = 0;
  int n_err = 0;

  seq_addsub #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .co        (co),
    .ov        (ov),
    .z         (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accepting edge, then scramble the inputs.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsel,
                          input logic tci);
    @(negedge clk);
    a        = ta;
    b        = tb;
    sel      = tsel;
    ci       = tci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ta ^ 16'hA5A5;
    b        = ~tb;
    sel      = ~tsel;
    ci       = ~tci;
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tsel, input logic tci, input logic [15:0] ey,
                        input logic eco, input logic eov, input logic ez);
    int cnt;
    start_op(ta, tb, tsel, tci);
    check({tag, "_busy"}, in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_lat"}, cnt, 4);
    check({tag, "_y"}, y, ey);
    check({tag, "_co"}, co, eco);
    check({tag, "_ov"}, ov, eov);
    check({tag, "_z"}, z, ez);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rdy"}, in_ready, 1);
    check({tag, "_ovld"}, out_valid, 0);
  endtask

  initial begin
    int cnt;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = 1'b0;
    ci        = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check("rst_ready", in_ready, 1);
    check("rst_ovld", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags", {co, ov, z}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add", 16'h1234, 16'h0FCE, 1'b0, 1'b0, 16'h2202, 1'b0, 1'b0, 1'b0);
    run_op("subz", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("subneg", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Stall in DONE: 0x8000 - 1 = 0x7FFF with carry and signed overflow.
    start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("stall_lat", cnt, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_y", y, 16'h7FFF);
      check("stall_flags", {co, ov, z}, 3'b110);
      check("stall_busy", in_ready, 0);
      check("stall_ovld", out_valid, 1);
      in_valid = ~in_valid;
      a        = 16'h0100 + 16'(i);
    end
    // Release together with in_valid: must not start a new operation.
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stall_rel_rdy", in_ready, 1);
    check("stall_rel_ovld", out_valid, 0);

    // Reset after two RUN cycles discards the operation.
    start_op(16'h1234, 16'h0FCE, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("mid_y_partial", y, 16'h0002);
    rst_n = 1'b0;
    #1;
    check("mid_rst_y", y, 0);
    check("mid_rst_flags", {co, ov, z}, 0);
    check("mid_rst_rdy", in_ready, 1);
    check("mid_rst_ovld", out_valid, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_hold", out_valid, 0);
    rst_n = 1'b1;
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 4, meaning bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 The module SHALL have port CLK, input, 1, the single clock, rising-edge active.
REQ-004 The module SHALL have port RST_N, input, 1, the asynchronous active-low reset.
REQ-005 The module SHALL have port IN_VALID, input, 1, meaning the operands are presented.
REQ-006 The module SHALL have port IN_READY, output, 1, meaning the block accepts an operation.
REQ-007 The module SHALL have ports A and B, input, WIDTH each, the operands.
REQ-008 The module SHALL have port SEL, input, 1, where 0 selects add and 1 selects subtract (B inverted).
REQ-009 The module SHALL have port CI, input, 1, the carry-in to bit 0.
REQ-010 The module SHALL have port OUT_VALID, output, 1, meaning the result is available.
REQ-011 The module SHALL have port OUT_READY, input, 1, meaning the consumer takes the result.
REQ-012 The module SHALL have port Y, output, WIDTH, the result.
REQ-013 The module SHALL have port CO, output, 1, the carry-out of the MSB.
REQ-014 The module SHALL have port OV, output, 1, the signed overflow flag.
REQ-015 The module SHALL have port Z, output, 1, asserted when Y is all zeros.

Function
REQ-016 The result SHALL equal {CO,Y} = A + (B XOR {WIDTH{SEL}}) + CI, computed modulo 2^(WIDTH+1); true subtraction requires SEL=1 with CI=1.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IN_READY SHALL be 1 only in IDLE, decoded from the state.
REQ-019 An operation SHALL be accepted on a rising edge with IN_VALID=1 and IN_READY=1; A, B, SEL and CI SHALL be registered on that edge, later input changes SHALL be ignored, and the state SHALL go IDLE->RUN with the chunk counter at 0.
REQ-020 Each RUN cycle SHALL process chunk index k (bits k*CHUNK+CHUNK-1 : k*CHUNK) using the stored carry, write that Y slice, update the carry register, and increment k.
REQ-021 Chunk 0 SHALL use CI as carry-in; chunk k>0 SHALL use the carry-out of chunk k-1.
REQ-022 On the edge processing chunk NCH-1, the state SHALL go RUN->DONE, CO SHALL take the final carry, OV SHALL take the carry into the MSB XOR the carry out of the MSB, and Z SHALL take (final Y == 0).
REQ-023 OUT_VALID SHALL be 1 only in DONE and SHALL rise exactly NCH rising edges after the accepting edge.
REQ-024 In DONE, Y, CO, OV and Z SHALL hold stable until a rising edge with OUT_READY=1, which SHALL move the state DONE->IDLE.
REQ-025 Y, CO, OV and Z SHALL NOT retain significance outside DONE; flags SHALL be cleared on acceptance.
REQ-026 IN_VALID SHALL be ignored in RUN and DONE; IN_VALID and OUT_READY asserted in the same cycle in DONE SHALL NOT accept a new operation.
REQ-027 OUT_READY SHALL be ignored outside DONE.
REQ-028 Counter width SHALL be $clog2(NCH), with a minimum of 1; with NCH=1, RUN SHALL last exactly one cycle.

Reset
REQ-029 Asserting RST_N low SHALL immediately force IDLE, counter 0, carry 0, Y=0, CO=0, OV=0, Z=0, OUT_VALID=0, and IN_READY=1.
REQ-030 A reset during RUN or DONE SHALL discard the in-flight operation with no result produced; the first accept after deassertion SHALL behave as from power-up.

Structure
REQ-031 A shared package addsub_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the default WIDTH/CHUNK constants.
REQ-032 One sub-module chunk_addsub (parameter CHUNK; inputs A, B, SEL, CI; outputs Y, CO, CMSB = carry into its top bit) SHALL be instantiated once and reused each RUN cycle.
REQ-033 All outputs except IN_READY and OUT_VALID SHALL be driven directly from flops.

Verification (WIDTH=16, CHUNK=4)
REQ-034 Stimulus A=0x1234, B=0x0FCE, SEL=0, CI=0 SHALL produce Y=0x2202, CO=0, OV=0, Z=0, with OUT_VALID exactly 4 edges after accept.
REQ-035 Stimulus A=0x0005, B=0x0005, SEL=1, CI=1 SHALL produce Y=0x0000, CO=1, Z=1, OV=0.
REQ-036 Stimulus A=0x7FFF, B=0x0001, SEL=0, CI=0 SHALL produce Y=0x8000, OV=1, CO=0, Z=0; stimulus A=0xFFFF, B=0x0001 SHALL produce Y=0x0000, CO=1, Z=1, OV=0.
REQ-037 Holding OUT_READY=0 for 10 cycles in DONE SHALL keep Y and the flags stable and IN_READY=0; IN_VALID pulses during that time SHALL be ignored, and after OUT_READY=1, IN_READY=1 on the next cycle.
REQ-038 With inputs changed after accept, the result SHALL match the operands captured at accept.
REQ-039 RST_N low after 2 RUN cycles SHALL clear all outputs asynchronously with no OUT_VALID, and a following op 0x0001+0x0001 SHALL produce Y=0x0002.
